// File: rtl/register_unit.sv
// RV32I integer register file: two combinational read ports, one write port, and a
// post-reset sweep that zeroes x1..x31 before raising ready.
module register_unit #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [WIDTH-1:0]  data_wr,
    input  logic              ru_wr,
    output logic [WIDTH-1:0]  ru_rs1,
    output logic [WIDTH-1:0]  ru_rs2,
    output logic              ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    // Entry 0 is never written, so x0 reads as zero through the read-mux guard.
    logic [WIDTH-1:0]  regs_q [0:DEPTH-1];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_en     = 1'b0;
        wr_addr   = rd;
        wr_data   = data_wr;
        if (state_q == ST_CLEAR) begin
            wr_en     = 1'b1;
            wr_addr   = clr_ptr_q;
            wr_data   = '0;
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end else begin
            wr_en = ru_wr && (rd != '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // NOTE: the array has no reset term; the sweep clears it, which keeps it mappable to plain storage.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign ready = (state_q == ST_RUN);

    // No write bypass: a same-cycle write becomes visible only after the edge.
    assign ru_rs1 = (ready && (rs1 != '0)) ? regs_q[rs1] : '0;
    assign ru_rs2 = (ready && (rs2 != '0)) ? regs_q[rs2] : '0;

endmodule

// File: tb/tb_register_unit.sv
// Self-checking bench for register_unit: directed vector table, sweep/reset
// sequences, and randomized traffic against a behavioural register-file model.
module tb_register_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] data_wr;
    logic        ru_wr;
    logic [31:0] ru_rs1, ru_rs2;
    logic        ready;

    int n_total = 0;
    int n_pass  = 0;

    // Model: registers plus the number of non-reset edges since the last reset.
    logic [31:0] m_regs [32];
    int          m_edges = 0;

    register_unit #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
        .data_wr(data_wr), .ru_wr(ru_wr),
        .ru_rs1(ru_rs1), .ru_rs2(ru_rs2), .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pre1;
        logic [31:0] post1;
        logic [31:0] post2;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic m_ready();
        return m_edges >= 31;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        return (m_ready() && idx != 0) ? m_regs[idx] : 32'h0;
    endfunction

    task automatic tick();
        if (rst) begin
            m_edges = 0;
        end else if (m_edges < 31) begin
            m_edges++;
            m_regs[m_edges] = 32'h0;
        end else if (ru_wr && rd != 0) begin
            m_regs[rd] = data_wr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        #1;
        check({tag, " ready"},  {31'h0, ready}, {31'h0, m_ready()});
        check({tag, " ru_rs1"}, ru_rs1, m_read(rs1));
        check({tag, " ru_rs2"}, ru_rs2, m_read(rs2));
    endtask

    // Pulse reset, then verify ready stays low for exactly 31 edges with reads forced to 0.
    task automatic reset_and_sweep(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            #1;
            check({tag, " ready low"}, {31'h0, ready}, 32'h0);
            check({tag, " rs1 forced 0"}, ru_rs1, 32'h0);
            tick();
        end
        #1;
        check({tag, " ready high"}, {31'h0, ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; ru_wr = 1'b0; rd = '0; rs1 = '0; rs2 = '0; data_wr = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        vecs[0] = '{1'b1, 5'd3, 32'h0000000F, 5'd3, 5'd3, 32'h0, 32'h0000000F, 32'h0000000F};
        vecs[1] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0};
        vecs[2] = '{1'b0, 5'd7, 32'hF0000000, 5'd7, 5'd3, 32'h0, 32'h0,        32'h0000000F};
        vecs[3] = '{1'b1, 5'd7, 32'hF0000000, 5'd7, 5'd7, 32'h0, 32'hF0000000, 32'hF0000000};
        vecs[4] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[5] = '{1'b1, 5'd3, 32'h00000001, 5'd3, 5'd7, 32'h0000000F, 32'h00000001, 32'hF0000000};

        #1;
        reset_and_sweep("init");

        for (int v = 0; v < 6; v++) begin
            ru_wr = vecs[v].wr; rd = vecs[v].rd; data_wr = vecs[v].data;
            rs1 = vecs[v].rs1; rs2 = vecs[v].rs2;
            #1;
            check($sformatf("vec%0d pre rs1", v), ru_rs1, vecs[v].pre1);
            tick();
            ru_wr = 1'b0;
            #1;
            check($sformatf("vec%0d post rs1", v), ru_rs1, vecs[v].post1);
            check($sformatf("vec%0d post rs2", v), ru_rs2, vecs[v].post2);
        end

        // x5 holds DEADBEEF; sweep with a write to x9 held throughout.
        rs1 = 5'd5; rs2 = 5'd9;
        ru_wr = 1'b1; rd = 5'd9; data_wr = 32'h12345678;
        reset_and_sweep("sweep");
        check("x5 cleared", ru_rs1, 32'h0);
        check("x9 write ignored", ru_rs2, 32'h0);
        ru_wr = 1'b0;

        // Reset landing on sweep edge 15.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int e = 1; e < 15; e++) tick();
        reset_and_sweep("mid");

        // Reset landing on the final sweep edge.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int e = 1; e < 31; e++) tick();
        reset_and_sweep("last");

        // Fill every register with an index pattern and read all neighbouring pairs.
        ru_wr = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rd = 5'(i); data_wr = 32'(i) * 32'h01010101 ^ 32'hA5000000;
            tick();
        end
        ru_wr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'((i + 1) % 32);
            check_model($sformatf("fill%0d", i));
        end
        reset_and_sweep("refill");
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            check_model($sformatf("zero%0d", i));
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(0, 79) == 0);
            ru_wr   = $urandom_range(0, 1) == 1;
            rd      = 5'($urandom_range(0, 31));
            data_wr = $urandom;
            rs1     = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2     = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
            check_model("rand");
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_unit.md
Name: register_unit

Overview:
- RV32I 32x32 integer register file for the monocycle CPU; sits between decode/write-back and the ALU operand inputs.
- Two asynchronous read ports (rs1, rs2) and one synchronous write port (rd).
- After reset, a sweep state machine zeroes x1..x31, one register per cycle, then raises ready; the core must hold off until ready=1.

Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of architectural registers (x0..x31)
- ADDR_W, 5, register index width (log2 DEPTH)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- rs1  input  ADDR_W  read index, port 1
- rs2  input  ADDR_W  read index, port 2
- rd  input  ADDR_W  write index
- data_wr  input  WIDTH  write data
- ru_wr  input  1  write enable
- ru_rs1  output  WIDTH  read data, port 1
- ru_rs2  output  WIDTH  read data, port 2
- ready  output  1  high once the post-reset clear sweep has completed

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. rst is sampled only on the rising edge of clk and dominates every other input.
- States:
  - CLEAR: sweep in progress.
  - RUN: normal operation.
- Sweep pointer: clr_ptr, ADDR_W bits wide.
- Any edge with rst=1 forces state=CLEAR and clr_ptr=1 from any state, including mid-sweep and RUN. No register is written on an rst=1 edge.
- CLEAR with rst=0, at each edge:
  - reg[clr_ptr] <= 0, then clr_ptr <= clr_ptr+1.
  - On the edge that clears x31 (clr_ptr=DEPTH-1), state <= RUN.
  - Exactly DEPTH-1 = 31 edges with rst=0 after the last rst=1 edge; ready is asserted after the 31st.
- ready = (state==RUN). Registered, so 0 from the first rst edge onward. No combinational path from inputs.
- While ready=0:
  - ru_wr is ignored and no write occurs.
  - ru_rs1 and ru_rs2 are forced to 0.
- RUN, writes:
  - At the edge with ru_wr=1 and rd!=0, reg[rd] <= data_wr.
  - ru_wr=1 with rd=0 has no effect.
- RUN, reads:
  - ru_rs1 = (rs1==0) ? 0 : reg[rs1], purely combinational from rs1 and array contents; ru_rs2 likewise.
  - No write-to-read bypass. A read of rd in the same cycle as its write returns the old value until the edge; the new value is visible immediately after the edge. This avoids a combinational loop through the ALU in the monocycle datapath.
- x0 reads 0 in every state; reg[0] need not exist as storage.
- rs1==rs2 is legal; both ports return the same value.
- Uninitialised storage before the first reset: outputs are don't-care, but ready is 0 after any reset edge.
- Reset at the sweep's final edge (clr_ptr=31, rst=1): rst wins; the sweep restarts at 1 and ready stays 0.
- Implementation: register array plus 2-state FSM and pointer; two read muxes; no latches.

Test Plan:
- Reset sweep:
  - Preload x5=0xDEADBEEF in RUN.
  - Pulse rst for 1 cycle.
  - ready=0 for 31 edges and rises after the 31st.
  - Reading x5 then returns 0x00000000.
  - ru_rs1 reads 0 throughout the sweep.
- Write/read:
  - In RUN, write rd=3, data_wr=0x0000000F, ru_wr=1.
  - rs1=3 shows the old value (0) before the edge and 0x0000000F after it.
  - rs2=3 matches rs1.
- x0 protection:
  - Write rd=0, data_wr=0xFFFFFFFF.
  - rs1=0 and rs2=0 both read 0x00000000 permanently.
- Write enable:
  - rd=7, data_wr=0xF0000000, ru_wr=0 → x7 unchanged (0).
  - Then ru_wr=1 → x7=0xF0000000.
- Write during sweep:
  - ru_wr=1, rd=9, data_wr=0x12345678 held throughout CLEAR.
  - After ready=1, x9 reads 0x00000000.
- Reset mid-sweep and full sweep:
  - Assert rst at sweep edge 15 → ready stays 0 until 31 edges after that rst release.
  - Fill all x1..x31 with index-based patterns, read every pair via rs1/rs2, then reset → all read 0 after ready.
